fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Fetch-stage PC register and branch-prediction tracker for the 5-stage pipeline. It holds PCF, which addresses the direction predictor and I-cache, and loads the predictor's next-PC choice each cycle. It also carries each fetched instruction's prediction (taken bit, predicted target) through IF/ID and ID/EX. In EX it compares the prediction with the resolved branch, and on a mismatch redirects PCF and squashes the two younger instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_f  in  1  hold PCF (hazard unit)
- stall_d  in  1  hold IF/ID register
- flush_e  in  1  load bubble into ID/EX (hazard unit)
- paddrf  in  32  predicted next PC from predictor
- pdf  in  1  predictor says taken for PCF
- BranchE  in  1  branch in EX actually taken
- BranchTypeE  in  3  nonzero = EX instruction is a branch
- BrNPC  in  32  resolved branch target in EX
- pcf  out  32  current fetch PC (predictor addr)
- pc_d  out  32  PC of instruction in ID
- valid_d  out  1  ID slot holds a real instruction
- pc_e  out  32  PC of instruction in EX
- mispredict_e  out  1  EX prediction wrong, redirect this cycle
- redirect_pc  out  32  correct next PC when mispredict_e
- pred_ok_e  out  1  valid EX branch whose prediction was correct
- branch_cnt  out  CNT_W  resolved branches
- miss_cnt  out  CNT_W  mispredictions

Clocking and reset are fixed: single clock clk; reset rst_n is asynchronous and active-low.

## Operation
- PCF register:
  - mispredict_e=1: load redirect_pc, regardless of stall_f.
  - Otherwise stall_f=1: hold.
  - Otherwise: load paddrf.
- IF/ID register (pc_d, pred_d=pdf, tgt_d=paddrf, valid_d):
  - mispredict_e=1: valid_d←0 and pred_d←0. This overrides stall_d.
  - Otherwise stall_d=1: hold.
  - Otherwise: capture pcf, pdf, paddrf, valid_d←1.
- ID/EX register (pc_e, pred_e, tgt_e, valid_e):
  - mispredict_e=1 or flush_e=1: bubble (valid_e←0, pred_e←0).
  - Otherwise: copy from IF/ID. The hazard unit asserts flush_e whenever stall_d=1.
- EX resolution (combinational), when valid_e=1:
  - Branch (BranchTypeE≠0):
    - mispredict_e = (BranchE≠pred_e) | (BranchE & pred_e & tgt_e≠BrNPC)
    - redirect_pc = BranchE ? BrNPC : pc_e+4
  - Non-branch with pred_e=1 (BTB alias hit): mispredict_e=1, redirect_pc=pc_e+4.
  - Non-branch with pred_e=0: no action.
- When valid_e=0: mispredict_e=0, pred_ok_e=0, redirect_pc=pc_e+4.
- pred_ok_e = valid_e & (BranchTypeE≠0) & ~mispredict_e.
- PC arithmetic is modulo 2^32, so pc_e=32'hFFFF_FFFC gives redirect 0.
- Counters, updated at the clock edge:
  - branch_cnt +1 when valid_e & BranchTypeE≠0.
  - miss_cnt +1 when mispredict_e.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset values: pcf=RESET_PC; pc_d=pc_e=0; valid_d=valid_e=0; pred/tgt registers 0; mispredict_e=0; pred_ok_e=0; redirect_pc=4; branch_cnt=miss_cnt=0.
- Reset is asynchronous. Asserting it mid-operation clears everything immediately; fetch restarts from RESET_PC on the first edge after rst_n deasserts.
- Prediction latency: pdf/paddrf for PCF are sampled at the edge that advances PCF. A correctly predicted taken branch therefore has zero bubbles.
- Misprediction penalty:
  - mispredict_e is combinational in cycle N.
  - At edge N+1: PCF=redirect_pc, and ID and EX hold bubbles.
  - Penalty is 2 cycles.
- Simultaneous events:
  - mispredict_e beats stall_f, stall_d and flush_e.
  - flush_e without mispredict_e does not touch PCF or IF/ID.
- Counter outputs are registered and lag the event by one cycle.

## Test plan
- Reset release with stall_f=0 and paddrf=pcf+4 -> pcf steps 0,4,8,12; valid_d=1 from the second cycle; counters stay 0.
- Branch at 0x10, pdf=1, paddrf=0x40; two cycles later BranchE=1, BrNPC=0x40 -> pred_ok_e=1, no redirect, branch_cnt=1, miss_cnt=0.
- Same branch with BranchE=0 -> mispredict_e=1, redirect_pc=0x14; next edge pcf=0x14, valid_d=0, valid_e=0; miss_cnt=1.
- pdf=1 on a non-branch at 0x20 (BranchTypeE=0 in EX) -> mispredict_e=1, redirect_pc=0x24.
- stall_f=1 and stall_d=1 in the same cycle as a mispredict -> pcf still loads redirect_pc, IF/ID is squashed; with stall only (no mispredict) pcf and pc_d hold.
- Preload miss_cnt to all-ones, then force a mispredict -> miss_cnt stays all-ones. Assert rst_n=0 mid-stream -> all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register plus a per-instruction prediction tracker carried through IF/ID and ID/EX.
// Branches are resolved in EX. A wrong prediction redirects PCF and squashes the two younger slots.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_e,
    input  logic [31:0]      paddrf,
    input  logic             pdf,
    input  logic             BranchE,
    input  logic [2:0]       BranchTypeE,
    input  logic [31:0]      BrNPC,
    output logic [31:0]      pcf,
    output logic [31:0]      pc_d,
    output logic             valid_d,
    output logic [31:0]      pc_e,
    output logic             mispredict_e,
    output logic [31:0]      redirect_pc,
    output logic             pred_ok_e,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    logic [31:0]      pcf_q;
    logic [31:0]      pcd_q;
    logic             predd_q;
    logic [31:0]      tgtd_q;
    logic             vald_q;
    logic [31:0]      pce_q;
    logic             prede_q;
    logic [31:0]      tgte_q;
    logic             vale_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic             is_branch;
    logic             mispredict_d;
    logic [31:0]      redirect_d;
    logic [31:0]      pce_plus4;

    assign is_branch = (BranchTypeE != 3'd0);
    assign pce_plus4 = pce_q + 32'd4;

    always_comb begin
        mispredict_d = 1'b0;
        redirect_d   = pce_plus4;
        if (vale_q) begin
            if (is_branch) begin
                // A taken prediction is only right if the predicted target also matches.
                mispredict_d = (BranchE != prede_q) | (BranchE & prede_q & (tgte_q != BrNPC));
                redirect_d   = BranchE ? BrNPC : pce_plus4;
            end else if (prede_q) begin
                mispredict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q   <= RESET_PC;
            pcd_q   <= 32'd0;
            predd_q <= 1'b0;
            tgtd_q  <= 32'd0;
            vald_q  <= 1'b0;
        end else if (mispredict_d) begin
            pcf_q   <= redirect_d;
            predd_q <= 1'b0;
            vald_q  <= 1'b0;
        end else begin
            if (!stall_f) begin
                pcf_q <= paddrf;
            end
            if (!stall_d) begin
                pcd_q   <= pcf_q;
                predd_q <= pdf;
                tgtd_q  <= paddrf;
                vald_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pce_q   <= 32'd0;
            prede_q <= 1'b0;
            tgte_q  <= 32'd0;
            vale_q  <= 1'b0;
        end else if (mispredict_d || flush_e) begin
            prede_q <= 1'b0;
            vale_q  <= 1'b0;
        end else begin
            pce_q   <= pcd_q;
            prede_q <= predd_q;
            tgte_q  <= tgtd_q;
            vale_q  <= vald_q;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (vale_q && is_branch && (branch_cnt_q != {CNT_W{1'b1}})) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict_d && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign pcf          = pcf_q;
    assign pc_d         = pcd_q;
    assign valid_d      = vald_q;
    assign pc_e         = pce_q;
    assign mispredict_e = mispredict_d;
    assign redirect_pc  = redirect_d;
    assign pred_ok_e    = vale_q & is_branch & ~mispredict_d;
    assign branch_cnt   = branch_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: hand-traced pipeline sequence with a narrow counter width
// so that the saturation of miss_cnt is reachable.
module tb_fetch_pc_ctrl;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             stall_f;
    logic             stall_d;
    logic             flush_e;
    logic [31:0]      paddrf;
    logic             pdf;
    logic             BranchE;
    logic [2:0]       BranchTypeE;
    logic [31:0]      BrNPC;
    logic [31:0]      pcf;
    logic [31:0]      pc_d;
    logic             valid_d;
    logic [31:0]      pc_e;
    logic             mispredict_e;
    logic [31:0]      redirect_pc;
    logic             pred_ok_e;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int checks;
    int errors;

    fetch_pc_ctrl #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_e     (flush_e),
        .paddrf      (paddrf),
        .pdf         (pdf),
        .BranchE     (BranchE),
        .BranchTypeE (BranchTypeE),
        .BrNPC       (BrNPC),
        .pcf         (pcf),
        .pc_d        (pc_d),
        .valid_d     (valid_d),
        .pc_e        (pc_e),
        .mispredict_e(mispredict_e),
        .redirect_pc (redirect_pc),
        .pred_ok_e   (pred_ok_e),
        .branch_cnt  (branch_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Present next-PC prediction, then advance one clock; returns 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic p);
        paddrf = a;
        pdf    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [2:0] bt, input logic taken, input logic [31:0] npc);
        BranchTypeE = bt;
        BranchE     = taken;
        BrNPC       = npc;
        #1;
    endtask

    task automatic set_stall(input logic s);
        stall_f = s;
        stall_d = s;
        flush_e = s;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        paddrf      = 32'h4;
        pdf         = 1'b0;
        BranchE     = 1'b0;
        BranchTypeE = 3'd0;
        BrNPC       = 32'h0;
        set_stall(1'b0);
        #2;
        check_val("rst_pcf",      pcf,                32'h0);
        check_val("rst_valid_d",  32'(valid_d),       32'h0);
        check_val("rst_pc_e",     pc_e,               32'h0);
        check_val("rst_mispred",  32'(mispredict_e),  32'h0);
        check_val("rst_redirect", redirect_pc,        32'h4);
        check_val("rst_brcnt",    32'(branch_cnt),    32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch 0,4,8,12
        step(32'h4, 1'b0);
        check_val("seq_pcf1", pcf, 32'h4);
        check_val("seq_vd1",  32'(valid_d), 32'h1);
        check_val("seq_pcd1", pc_d, 32'h0);
        step(32'h8, 1'b0);
        check_val("seq_pcf2", pcf, 32'h8);
        step(32'hC, 1'b0);
        check_val("seq_pcf3", pcf, 32'hC);
        check_val("seq_miss", 32'(miss_cnt), 32'h0);
        step(32'h10, 1'b0);

        // Correctly predicted taken branch at 0x10 -> 0x40
        step(32'h40, 1'b1);
        check_val("bt_pcf", pcf, 32'h40);
        step(32'h44, 1'b0);
        set_ex(3'd1, 1'b1, 32'h40);
        check_val("bt_pc_e",    pc_e, 32'h10);
        check_val("bt_pred_ok", 32'(pred_ok_e), 32'h1);
        check_val("bt_mispred", 32'(mispredict_e), 32'h0);
        step(32'h48, 1'b0);
        set_ex(3'd0, 1'b0, 32'h0);
        check_val("bt_pcf_next", pcf, 32'h48);
        check_val("bt_brcnt",    32'(branch_cnt), 32'h1);
        check_val("bt_miss",     32'(miss_cnt), 32'h0);

        // Same branch, actually not taken, with every stall asserted during the redirect
        step(32'h10, 1'b0);
        step(32'h40, 1'b1);
        step(32'h44, 1'b0);
        set_stall(1'b1);
        set_ex(3'd1, 1'b0, 32'h40);
        check_val("nt_mispred",  32'(mispredict_e), 32'h1);
        check_val("nt_redirect", redirect_pc, 32'h14);
        check_val("nt_pred_ok",  32'(pred_ok_e), 32'h0);
        step(32'h48, 1'b0);
        set_stall(1'b0);
        set_ex(3'd0, 1'b0, 32'h0);
        check_val("nt_pcf",     pcf, 32'h14);
        check_val("nt_valid_d", 32'(valid_d), 32'h0);
        check_val("nt_ex_bub",  32'(mispredict_e), 32'h0);
        check_val("nt_miss",    32'(miss_cnt), 32'h1);
        check_val("nt_brcnt",   32'(branch_cnt), 32'h2);

        // Plain stall: PCF and IF/ID hold
        step(32'h18, 1'b0);
        set_stall(1'b1);
        step(32'h1C, 1'b0);
        check_val("st_pcf",  pcf, 32'h18);
        check_val("st_pc_d", pc_d, 32'h14);
        check_val("st_vd",   32'(valid_d), 32'h1);
        set_stall(1'b0);
        step(32'h1C, 1'b0);
        check_val("st_pc_e", pc_e, 32'h14);

        // Predicted-taken non-branch at 0x20
        step(32'h20, 1'b0);
        step(32'h60, 1'b1);
        step(32'h64, 1'b0);
        check_val("al_pc_e",     pc_e, 32'h20);
        check_val("al_mispred",  32'(mispredict_e), 32'h1);
        check_val("al_redirect", redirect_pc, 32'h24);
        step(32'h68, 1'b0);
        check_val("al_pcf",  pcf, 32'h24);
        check_val("al_miss", 32'(miss_cnt), 32'h2);

        // Taken as predicted but to a different target
        step(32'h28, 1'b0);
        step(32'h80, 1'b1);
        step(32'h84, 1'b0);
        set_ex(3'd2, 1'b1, 32'h90);
        check_val("tg_mispred",  32'(mispredict_e), 32'h1);
        check_val("tg_redirect", redirect_pc, 32'h90);
        step(32'h88, 1'b0);
        set_ex(3'd0, 1'b0, 32'h0);
        check_val("tg_pcf",   pcf, 32'h90);
        check_val("tg_brcnt", 32'(branch_cnt), 32'h3);
        check_val("tg_miss",  32'(miss_cnt), 32'h3);

        // Redirect arithmetic wraps at the top of the address space
        step(32'hFFFF_FFFC, 1'b0);
        step(32'h100, 1'b1);
        step(32'h104, 1'b0);
        check_val("wr_pc_e",     pc_e, 32'hFFFF_FFFC);
        check_val("wr_redirect", redirect_pc, 32'h0);
        step(32'h108, 1'b0);
        check_val("wr_pcf",  pcf, 32'h0);
        check_val("wr_miss", 32'(miss_cnt), 32'h4);

        // Drive miss_cnt into saturation (3-bit counter tops out at 7)
        for (int i = 0; i < 4; i++) begin
            step(32'h200, 1'b1);
            step(32'h204, 1'b0);
            check_val("sat_mispred", 32'(mispredict_e), 32'h1);
            step(32'h208, 1'b0);
            check_val("sat_miss", 32'(miss_cnt), (i + 5 > 7) ? 32'h7 : 32'(i + 5));
        end

        // Asynchronous reset between clock edges
        step(32'h300, 1'b0);
        step(32'h304, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("ar_pcf",      pcf, 32'h0);
        check_val("ar_valid_d",  32'(valid_d), 32'h0);
        check_val("ar_pc_e",     pc_e, 32'h0);
        check_val("ar_redirect", redirect_pc, 32'h4);
        check_val("ar_miss",     32'(miss_cnt), 32'h0);
        check_val("ar_brcnt",    32'(branch_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h4, 1'b0);
        check_val("ar_restart", pcf, 32'h4);
        check_val("ar_pcd",     pc_d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
